redun_normalize: RTL and testbench
==================================

# redun_normalize

Word-serial carry-resolution engine that converts a redundant-form operand into a canonical binary field element. The operand has NUM_WRDS words of WRD_BITS+1 bits each, as produced by the redundant Montgomery multiplier. The block sits between the squaring core and the host/msu output path. It generalises the combinational from_redun/check_overflow helpers into a parametrised, throughput-configurable pipeline with a valid/ready handshake, an overflow flag and optional final modular subtraction.

## Interface
- WRD_BITS, 16: canonical bits per word; each redundant word is WRD_BITS+1 bits.
- NUM_WRDS, 65: words per operand. DAT_BITS = NUM_WRDS*WRD_BITS.
- WRDS_PER_CYC, 5: words resolved per beat; must divide NUM_WRDS. N_BEATS = NUM_WRDS/WRDS_PER_CYC.
- P, 1024-bit modulus zero-extended to DAT_BITS: used only when final subtraction is compiled in.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dat  in  NUM_WRDS*(WRD_BITS+1)  redundant operand, flat; word k at bits [k*(WRD_BITS+1) +: WRD_BITS+1].
- i_val  in  1  input valid.
- o_rdy  out  1  input ready.
- o_dat  out  DAT_BITS  canonical result.
- o_ovf  out  1  result overflowed 2^DAT_BITS (final carry non-zero).
- o_val  out  1  output valid.
- i_rdy  in  1  downstream ready.

## Operation
- FSM has three states: IDLE, RUN, DONE. o_rdy = (state==IDLE). o_val = (state==DONE).
- IDLE: when i_val&&o_rdy, latch i_dat into the operand register. Clear beat counter, carry (2 bits) and borrow (1 bit). Go to RUN.
- RUN, beat b (0..N_BEATS-1), for word k = b*WRDS_PER_CYC+j, j ascending:
  - s = in[k] + carry; res[k] = s[WRD_BITS-1:0]; carry = s >> WRD_BITS.
  - Carry never exceeds 2, so 2 bits suffice.
  - Chained combinationally across the WRDS_PER_CYC words of a beat; registered between beats.
- After beat N_BEATS-1: o_ovf = (carry!=0). Load o_dat and go to DONE.
- DONE: hold o_dat/o_ovf stable. When i_rdy, go to IDLE. i_val is ignored outside IDLE.
- No input is accepted while RUN or DONE. Throughput is one operand per N_BEATS+2 cycles minimum.
- Arithmetic is unsigned. Value = sum in[k]*2^(k*WRD_BITS). Without final subtraction, o_dat = value mod 2^DAT_BITS.

## Timing
- Reset (async assert, release sync to i_clk): state IDLE, o_val 0, o_ovf 0, o_dat 0, carry/borrow/counter 0. o_rdy is 1 during and after reset.
- Accept at edge t. Beats complete at edges t+1..t+N_BEATS. o_val rises after edge t+N_BEATS: latency N_BEATS cycles (13 at defaults), identical in both configurations.
- o_val falls on the edge where i_rdy is sampled high. o_rdy rises in the same cycle.
- i_rdy high on the first DONE cycle: single-cycle output, then IDLE.
- Reset mid-RUN or mid-DONE aborts immediately. Partial results are discarded and no o_val is produced.
- i_val held high across DONE: the next operand is accepted in the first IDLE cycle, not earlier.

## Configuration
- REDUN_NORM_FINAL_SUB_EN defined:
  - In parallel with each word add, compute d = res[k] - P[k] - borrow, keep d[k] mod 2^WRD_BITS and the new borrow.
  - At the final beat: if carry!=0 or borrow==0 (value >= P), o_dat = d (value-P mod 2^DAT_BITS); else o_dat = res.
  - o_ovf still reports the raw final carry. Correctness is required for value < 2P.
- Undefined: no P datapath. o_dat = res. Parameter P is unused.

## Test plan
- Reset, then all-zero operand -> o_val exactly 13 cycles after accept; o_dat 0, o_ovf 0, o_rdy low throughout RUN/DONE.
- Word0=0x10000, others 0 -> o_dat 0x10000 (carry into word1), o_ovf 0. Repeat with WRDS_PER_CYC=1 (65 beats) and 13 (5 beats) -> same result, latency 65/5.
- Word64=0x10000, others 0 -> o_ovf 1, o_dat 0 (without FINAL_SUB). All words 0x1FFFF -> o_dat equals from_redun model, o_ovf 1.
- Operand = P in canonical words -> o_dat P (macro off) / 0 (macro on). Operand = P-1 -> P-1 in both. Operand = P+5 with macro on -> 5.
- i_rdy low 10 cycles in DONE, i_val toggling -> o_dat/o_ovf stable, no second accept, single handshake on i_rdy.
- Assert i_rst_n low at beat 6 -> o_val 0 and o_rdy 1 immediately. A new operand after release yields a correct result with no residue from the aborted one.

Source files
------------

// File: rtl/redun_normalize.sv
// Word-serial carry resolution of a redundant-form operand into canonical binary,
// WRDS_PER_CYC words per beat. Define REDUN_NORM_FINAL_SUB_EN to add the final "- P" step.
module redun_normalize #(
  parameter int WRD_BITS     = 16,
  parameter int NUM_WRDS     = 65,
  parameter int WRDS_PER_CYC = 5,
  parameter logic [NUM_WRDS*WRD_BITS-1:0] P =
    {16'h0000, 16'hC000, {62{16'h0000}}, 16'h0001}
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_dat,
  input  logic                                i_val,
  output logic                                o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]        o_dat,
  output logic                                o_ovf,
  output logic                                o_val,
  input  logic                                i_rdy
);

  localparam int RW         = WRD_BITS + 1;
  localparam int DAT_BITS   = NUM_WRDS * WRD_BITS;
  localparam int OPW        = NUM_WRDS * RW;
  localparam int N_BEATS    = NUM_WRDS / WRDS_PER_CYC;
  localparam int BEAT_BITS  = WRDS_PER_CYC * WRD_BITS;
  localparam int BEAT_RBITS = WRDS_PER_CYC * RW;
  localparam int CNT_W      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       beat_q;
  logic [1:0]             carry_q;
  logic                   borrow_q;
  logic [OPW-1:0]         opnd_q;
  logic [DAT_BITS-1:0]    res_q;
  logic                   accept, last_beat;

  // Beat datapath: carry chain across the words of the current beat.
  logic [1:0]             cy;
  logic                   bw;
  logic [RW:0]            sum;
  logic [BEAT_BITS-1:0]   beat_res;
  logic [DAT_BITS-1:0]    res_next;
  logic [DAT_BITS-1:0]    fin_dat;

  assign accept    = (state_q == IDLE) && i_val;
  assign last_beat = (state_q == RUN) && (beat_q == CNT_W'(N_BEATS - 1));
  assign o_rdy     = (state_q == IDLE);
  assign o_val     = (state_q == DONE);

`ifdef REDUN_NORM_FINAL_SUB_EN
  logic [WRD_BITS:0]      diff;
  logic [BEAT_BITS-1:0]   beat_dif;
  logic [BEAT_BITS-1:0]   p_beat;
  logic [DAT_BITS-1:0]    dif_q, dif_next;
`endif

  // NOTE: every variable is given a default before the loop so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  // NOTE: blocking assignments here are intentional -- cy/bw are evaluated word by
  // word within one combinational pass to form the ripple chain.
  always_comb begin
    cy       = carry_q;
    bw       = borrow_q;
    sum      = '0;
    beat_res = '0;
`ifdef REDUN_NORM_FINAL_SUB_EN
    diff     = '0;
    beat_dif = '0;
    p_beat   = BEAT_BITS'(P >> (int'(beat_q) * BEAT_BITS));
`endif
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      sum = {1'b0, opnd_q[j*RW +: RW]} + (RW+1)'(cy);
      beat_res[j*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
      cy = sum[WRD_BITS +: 2];
`ifdef REDUN_NORM_FINAL_SUB_EN
      diff = {1'b0, sum[WRD_BITS-1:0]} - {1'b0, p_beat[j*WRD_BITS +: WRD_BITS]}
             - (WRD_BITS+1)'(bw);
      beat_dif[j*WRD_BITS +: WRD_BITS] = diff[WRD_BITS-1:0];
      bw = diff[WRD_BITS];
`endif
    end
  end

  // Results shift in from the top so word 0 lands at the bottom after N_BEATS beats.
  assign res_next = (res_q >> BEAT_BITS) | (DAT_BITS'(beat_res) << (DAT_BITS - BEAT_BITS));

`ifdef REDUN_NORM_FINAL_SUB_EN
  assign dif_next = (dif_q >> BEAT_BITS) | (DAT_BITS'(beat_dif) << (DAT_BITS - BEAT_BITS));
  // value >= P exactly when the sum overflowed or the subtraction did not borrow.
  assign fin_dat  = ((cy != 2'd0) || !bw) ? dif_next : res_next;
`else
  logic unused_p;
  assign unused_p = ^P ^ bw;
  assign fin_dat  = res_next;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_val)     state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    if (i_rdy)     state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: state and control use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      carry_q  <= '0;
      borrow_q <= 1'b0;
      o_dat    <= '0;
      o_ovf    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        beat_q   <= '0;
        carry_q  <= '0;
        borrow_q <= 1'b0;
      end else if (state_q == RUN) begin
        beat_q   <= beat_q + CNT_W'(1);
        carry_q  <= cy;
        borrow_q <= bw;
        if (last_beat) begin
          o_dat <= fin_dat;
          o_ovf <= (cy != 2'd0);
        end
      end
    end
  end

  // NOTE: the wide operand/partial-result registers carry no reset; they are fully
  // rewritten on every accept/beat and never observed before that.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      opnd_q <= i_dat;
    end else if (state_q == RUN) begin
      opnd_q <= opnd_q >> BEAT_RBITS;
      res_q  <= res_next;
`ifdef REDUN_NORM_FINAL_SUB_EN
      dif_q  <= dif_next;
`endif
    end
  end

endmodule

// File: tb/tb_redun_normalize.sv
// Self-checking bench for redun_normalize: vector table, random operands against an
// arithmetic model, and hand-written handshake/reset sequences.
module tb_redun_normalize;

  localparam int WB  = 16;
  localparam int NW  = 65;
  localparam int RW  = WB + 1;
  localparam int DAT = NW * WB;
  localparam int OPW = NW * RW;
  localparam logic [DAT-1:0] P_TB = (DAT'(1) << 1023) | (DAT'(1) << 1022) | DAT'(1);
`ifdef REDUN_NORM_FINAL_SUB_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic clk, rst_n;
  logic [OPW-1:0] i_dat;
  logic i_val, i_rdy, o_rdy, o_val, o_ovf;
  logic [DAT-1:0] o_dat;

  logic [OPW-1:0] dat_x;
  logic val_a, rdy_a, o_rdy_a, o_val_a, o_ovf_a;
  logic val_b, rdy_b, o_rdy_b, o_val_b, o_ovf_b;
  logic [DAT-1:0] o_dat_a, o_dat_b;

  redun_normalize #(.WRD_BITS(WB), .NUM_WRDS(NW), .WRDS_PER_CYC(5), .P(P_TB)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_val(i_val), .o_rdy(o_rdy),
    .o_dat(o_dat), .o_ovf(o_ovf), .o_val(o_val), .i_rdy(i_rdy));

  redun_normalize #(.WRD_BITS(WB), .NUM_WRDS(NW), .WRDS_PER_CYC(1), .P(P_TB)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(dat_x), .i_val(val_a), .o_rdy(o_rdy_a),
    .o_dat(o_dat_a), .o_ovf(o_ovf_a), .o_val(o_val_a), .i_rdy(rdy_a));

  redun_normalize #(.WRD_BITS(WB), .NUM_WRDS(NW), .WRDS_PER_CYC(13), .P(P_TB)) u_dut13 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(dat_x), .i_val(val_b), .o_rdy(o_rdy_b),
    .o_dat(o_dat_b), .o_ovf(o_ovf_b), .o_val(o_val_b), .i_rdy(rdy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DAT+1:0] got, input logic [DAT+1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h required hi=%h lo=%h", name,
               got[DAT+1:DAT-30], got[63:0], exp[DAT+1:DAT-30], exp[63:0]);
    end
  endtask

  function automatic logic [OPW-1:0] set_word(input logic [OPW-1:0] d, input int k,
                                              input logic [RW-1:0] w);
    d[k*RW +: RW] = w;
    return d;
  endfunction

  function automatic logic [OPW-1:0] to_redun(input logic [DAT-1:0] v);
    logic [OPW-1:0] d;
    d = '0;
    for (int k = 0; k < NW; k++) d[k*RW +: RW] = {1'b0, v[k*WB +: WB]};
    return d;
  endfunction

  // Reference: the operand's integer value, optionally reduced by P once.
  function automatic void model(input logic [OPW-1:0] d, output logic [DAT-1:0] dat,
                                output logic ovf);
    logic [DAT+1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v = v + ((DAT+2)'(d[k*RW +: RW]) << (k * WB));
    ovf = (v[DAT+1:DAT] != 2'd0);
    if (FS && (v >= (DAT+2)'(P_TB))) v = v - (DAT+2)'(P_TB);
    dat = v[DAT-1:0];
  endfunction

  task automatic run_op(input logic [OPW-1:0] d, input int hold, input bit toggle_val,
                        output logic [DAT-1:0] got_dat, output logic got_ovf, output int lat);
    bit rdy_ok, stable_ok;
    @(negedge clk);
    i_dat = d; i_val = 1'b1; i_rdy = 1'b0;
    @(posedge clk); #1;
    i_val = 1'b0;
    lat = 0; rdy_ok = 1'b1; stable_ok = 1'b1;
    while (!o_val && lat < 200) begin
      if (o_rdy) rdy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (o_rdy) rdy_ok = 1'b0;
    got_dat = o_dat; got_ovf = o_ovf;
    for (int h = 0; h < hold; h++) begin
      if (toggle_val) i_val = ~i_val;
      @(posedge clk); #1;
      if (o_dat !== got_dat || o_ovf !== got_ovf || !o_val || o_rdy) stable_ok = 1'b0;
    end
    i_val = 1'b0; i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    check("rdy_low_busy", rdy_ok, 1'b1);
    check("handshake", {o_rdy, o_val}, 2'b10);
    if (hold > 0) check("done_stable", stable_ok, 1'b1);
  endtask

  typedef struct {
    string           name;
    logic [OPW-1:0]  opnd;
    logic [DAT-1:0]  dat;
    logic            ovf;
  } vec_t;

  vec_t           tbl[8];
  logic [DAT-1:0] got_dat, exp_dat, hold_dat;
  logic           got_ovf, exp_ovf;
  logic [OPW-1:0] op, op_b;
  int             lat, lat_a, lat_b;
  logic [DAT-1:0] dat_a, dat_b;
  logic           ovf_a, ovf_b;

  initial begin
    tbl[0] = '{"zero",     '0,                                        '0,          1'b0};
    tbl[1] = '{"w0_carry", set_word('0, 0, 17'h10000),                DAT'(1) << 16, 1'b0};
    tbl[2] = '{"w64_ovf",  set_word('0, 64, 17'h10000),               FS ? DAT'(0) - P_TB : '0, 1'b1};
    tbl[3] = '{"p_exact",  to_redun(P_TB),                            FS ? '0 : P_TB, 1'b0};
    tbl[4] = '{"p_minus1", to_redun(P_TB - 1),                        P_TB - 1,    1'b0};
    tbl[5] = '{"p_plus5",  to_redun(P_TB + 5),                        FS ? DAT'(5) : P_TB + 5, 1'b0};
    tbl[6] = '{"chain2",   set_word(set_word('0, 0, 17'h1FFFF), 1, 17'h1FFFF),
               DAT'(36'h2_0000_FFFF), 1'b0};
    tbl[7] = '{"ripple",   set_word(to_redun('1), 0, 17'h10000),      FS ? DAT'(0) - P_TB : '0, 1'b1};

    i_val = 1'b0; i_rdy = 1'b0; i_dat = '0; rst_n = 1'b1;
    dat_x = '0; val_a = 1'b0; val_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ctl", {o_rdy, o_val, o_ovf}, 3'b100);
    check("reset_dat", o_dat, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].opnd, 0, 1'b0, got_dat, got_ovf, lat);
      check({tbl[i].name, "_dat"}, got_dat, tbl[i].dat);
      check({tbl[i].name, "_ovf"}, got_ovf, tbl[i].ovf);
      check({tbl[i].name, "_lat"}, lat, 13);
    end

    if (!FS) begin
      op = '0;
      for (int k = 0; k < NW; k++) op = set_word(op, k, 17'h1FFFF);
      model(op, exp_dat, exp_ovf);
      run_op(op, 0, 1'b0, got_dat, got_ovf, lat);
      check("all_ones_dat", got_dat, exp_dat);
      check("all_ones_ovf", got_ovf, exp_ovf);
    end

    for (int r = 0; r < 16; r++) begin
      op = '0;
      for (int k = 0; k < NW; k++)
        if (!FS || k < 63) op = set_word(op, k, RW'($urandom_range(0, 17'h1FFFF)));
      model(op, exp_dat, exp_ovf);
      run_op(op, 0, 1'b0, got_dat, got_ovf, lat);
      check("rand_dat", got_dat, exp_dat);
      check("rand_ovf", got_ovf, exp_ovf);
    end

    // Stall in DONE with i_val toggling.
    op = '0;
    for (int k = 0; k < 40; k++) op = set_word(op, k, RW'($urandom_range(0, 17'h1FFFF)));
    model(op, exp_dat, exp_ovf);
    run_op(op, 10, 1'b1, got_dat, got_ovf, lat);
    check("stall_dat", got_dat, exp_dat);
    check("stall_ovf", got_ovf, exp_ovf);

    // i_val held high across DONE: second operand taken only in the first IDLE cycle.
    op   = set_word(set_word('0, 3, 17'h1ABCD), 10, 17'h00042);
    op_b = set_word(set_word('0, 0, 17'h1FFFF), 7, 17'h12345);
    @(negedge clk);
    i_dat = op; i_val = 1'b1; i_rdy = 1'b1;
    @(posedge clk); #1;
    i_dat = op_b;
    lat = 0;
    while (!o_val && lat < 200) begin @(posedge clk); #1; lat++; end
    model(op, exp_dat, exp_ovf);
    check("held_a_dat", o_dat, exp_dat);
    check("held_a_lat", lat, 13);
    @(posedge clk); #1;
    check("held_idle", {o_rdy, o_val}, 2'b10);
    @(posedge clk); #1;
    check("held_accept", o_rdy, 1'b0);
    i_val = 1'b0;
    lat = 0;
    while (!o_val && lat < 200) begin @(posedge clk); #1; lat++; end
    model(op_b, exp_dat, exp_ovf);
    check("held_b_dat", o_dat, exp_dat);
    check("held_b_lat", lat, 13);
    @(posedge clk); #1;
    i_rdy = 1'b0;
    check("held_b_single", {o_rdy, o_val}, 2'b10);

    // Abort mid-RUN, then verify a clean result afterwards.
    @(negedge clk);
    i_dat = set_word(to_redun('1), 64, 17'h1FFFF); i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ctl", {o_rdy, o_val, o_ovf}, 3'b100);
    check("abort_dat", o_dat, '0);
    @(negedge clk) rst_n = 1'b1;
    op = set_word(set_word('0, 5, 17'h10001), 6, 17'h0FFFF);
    model(op, exp_dat, exp_ovf);
    run_op(op, 0, 1'b0, got_dat, got_ovf, lat);
    check("post_abort_dat", got_dat, exp_dat);
    check("post_abort_ovf", got_ovf, exp_ovf);
    check("post_abort_lat", lat, 13);

    // Same carry-into-word1 case at 1 and 13 words per beat.
    @(negedge clk);
    dat_x = set_word('0, 0, 17'h10000); val_a = 1'b1; val_b = 1'b1;
    @(posedge clk); #1;
    val_a = 1'b0; val_b = 1'b0;
    lat_a = -1; lat_b = -1;
    dat_a = '0; dat_b = '0; ovf_a = 1'b0; ovf_b = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (o_val_a && lat_a < 0) begin lat_a = c; dat_a = o_dat_a; ovf_a = o_ovf_a; end
      if (o_val_b && lat_b < 0) begin lat_b = c; dat_b = o_dat_b; ovf_b = o_ovf_b; end
    end
    check("w1_lat", lat_a, 65);
    check("w1_dat", dat_a, DAT'(1) << 16);
    check("w1_ovf", ovf_a, 1'b0);
    check("w13_lat", lat_b, 5);
    check("w13_dat", dat_b, DAT'(1) << 16);
    check("w13_ovf", ovf_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
